// File: rtl/ecc_apb_master.sv
// APB initiator for the ECC register bank: per command it writes DATA_IN,
// CODEWORD_WIDTH, NOISE and CTRL, then waits for operation_done (or a timeout)
// and returns one result beat.
module ecc_apb_master #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_ctrl,
  input  logic [1:0]                 cmd_width,
  input  logic [DATA_WIDTH-1:0]      cmd_data,
  input  logic [DATA_WIDTH-1:0]      cmd_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       res_valid,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [1:0]                 res_errors,
  output logic                       res_timeout
);

  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL  = AMBA_ADDR_WIDTH'(4'h0);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA  = AMBA_ADDR_WIDTH'(4'h4);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH = AMBA_ADDR_WIDTH'(4'h8);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE = AMBA_ADDR_WIDTH'(4'hC);
  localparam logic [7:0]                 CNT_LAST   = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   idx_q, idx_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic [1:0]                   ctrl_q, ctrl_d;
  logic [1:0]                   width_q, width_d;
  logic [DATA_WIDTH-1:0]        data_q, data_d;
  logic [DATA_WIDTH-1:0]        noise_q, noise_d;
  logic [AMBA_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [AMBA_WORD-1:0]         pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0]        res_data_q, res_data_d;
  logic [1:0]                   res_errors_q, res_errors_d;
  logic                         res_timeout_q, res_timeout_d;
  logic                         load_wr;
  logic [1:0]                   wr_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      ctrl_q        <= '0;
      width_q       <= '0;
      data_q        <= '0;
      noise_q       <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      res_data_q    <= '0;
      res_errors_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      ctrl_q        <= ctrl_d;
      width_q       <= width_d;
      data_q        <= data_d;
      noise_q       <= noise_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      res_data_q    <= res_data_d;
      res_errors_q  <= res_errors_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    ctrl_d        = ctrl_q;
    width_d       = width_q;
    data_d        = data_q;
    noise_d       = noise_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    res_data_d    = res_data_q;
    res_errors_d  = res_errors_q;
    res_timeout_d = res_timeout_q;
    load_wr       = 1'b0;
    wr_idx        = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ctrl_d  = cmd_ctrl;
          width_d = cmd_width;
          data_d  = cmd_data;
          noise_d = cmd_noise;
          idx_d   = '0;
          load_wr = 1'b1;
          wr_idx  = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (idx_q == 2'd3) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          load_wr = 1'b1;
          wr_idx  = idx_q + 2'd1;
          state_d = S_SETUP;
        end
      end
      S_WAIT_DONE: begin
        // done has priority over a timeout expiring in the same cycle
        if (operation_done) begin
          res_data_d    = data_out;
          res_errors_d  = num_of_errors;
          res_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) begin
            res_data_d    = '0;
            res_errors_d  = '0;
            res_timeout_d = 1'b1;
            state_d       = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // First write takes the live command word since the latch is not yet visible
    if (load_wr) begin
      case (wr_idx)
        2'd0: begin paddr_d = ADDR_DATA;  pwdata_d = AMBA_WORD'(cmd_data); end
        2'd1: begin paddr_d = ADDR_WIDTH; pwdata_d = AMBA_WORD'(width_q);  end
        2'd2: begin paddr_d = ADDR_NOISE; pwdata_d = AMBA_WORD'(noise_q);  end
        default: begin paddr_d = ADDR_CTRL; pwdata_d = AMBA_WORD'(ctrl_q); end
      endcase
    end
  end

  assign cmd_ready   = rst && (state_q == S_IDLE);
  assign PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE     = (state_q == S_ACCESS);
  assign PWRITE      = PSEL;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign res_valid   = (state_q == S_RESP);
  assign res_data    = res_data_q;
  assign res_errors  = res_errors_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_ecc_apb_master.sv
// Directed bench for ecc_apb_master: expected APB writes and result beats are
// queued when a command is issued and checked by monitors when they appear.
module tb_ecc_apb_master;
  localparam int AW  = 32;
  localparam int ADW = 20;
  localparam int DW  = 32;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_ctrl = '0;
  logic [1:0]     cmd_width = '0;
  logic [DW-1:0]  cmd_data = '0;
  logic [DW-1:0]  cmd_noise = '0;
  logic [ADW-1:0] PADDR;
  logic           PSEL, PENABLE, PWRITE;
  logic [AW-1:0]  PWDATA;
  logic           operation_done = 1'b0;
  logic [DW-1:0]  data_out = '0;
  logic [1:0]     num_of_errors = '0;
  logic           res_valid;
  logic [DW-1:0]  res_data;
  logic [1:0]     res_errors;
  logic           res_timeout;

  ecc_apb_master #(
    .AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctrl(cmd_ctrl),
    .cmd_width(cmd_width), .cmd_data(cmd_data), .cmd_noise(cmd_noise),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .res_valid(res_valid), .res_data(res_data), .res_errors(res_errors),
    .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [ADW+AW-1:0] wr_q[$];
  logic [DW+2:0]     res_q[$];   // {timeout, errors, data}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // APB monitor: every ACCESS must follow a SETUP with identical address/data
  logic [ADW-1:0] su_addr;
  logic [AW-1:0]  su_data;
  bit             su_seen = 0;
  always @(negedge clk) begin
    logic [ADW+AW-1:0] e;
    if (PSEL && !PENABLE) begin
      su_addr = PADDR;
      su_data = PWDATA;
      su_seen = 1;
      chk("setup_pwrite", PWRITE, 1);
    end else if (PSEL && PENABLE) begin
      e = (wr_q.size() > 0) ? wr_q.pop_front() : '1;
      chk("access_after_setup", su_seen, 1);
      chk("paddr_stable", PADDR, su_addr);
      chk("pwdata_stable", PWDATA, su_data);
      chk("access_pwrite", PWRITE, 1);
      chk("apb_addr", PADDR, e[ADW+AW-1:AW]);
      chk("apb_wdata", PWDATA, e[AW-1:0]);
      su_seen = 0;
    end else begin
      su_seen = 0;
    end
  end

  always @(negedge clk) begin
    logic [DW+2:0] e;
    if (res_valid) begin
      e = (res_q.size() > 0) ? res_q.pop_front() : '1;
      chk("res_data", res_data, e[DW-1:0]);
      chk("res_errors", res_errors, e[DW+1:DW]);
      chk("res_timeout", res_timeout, e[DW+2]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] c, input logic [1:0] w, input logic [DW-1:0] d,
                          input logic [DW-1:0] n, input logic [DW+2:0] r);
    wr_q.push_back({ADW'(4'h4), AW'(d)});
    wr_q.push_back({ADW'(4'h8), AW'(w)});
    wr_q.push_back({ADW'(4'hC), AW'(n)});
    wr_q.push_back({ADW'(4'h0), AW'(c)});
    res_q.push_back(r);
  endtask

  // Leaves the bench 1 time unit into cycle 1 (first SETUP)
  task automatic issue(input logic [1:0] c, input logic [1:0] w, input logic [DW-1:0] d,
                       input logic [DW-1:0] n, input logic [DW+2:0] r);
    int t = 0;
    while (!cmd_ready && t < 200) begin step(); t++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_ctrl = c; cmd_width = w; cmd_data = d; cmd_noise = n;
    push_cmd(c, w, d, n, r);
    step();
    cmd_valid = 1'b0; cmd_data = $urandom; cmd_noise = $urandom; cmd_ctrl = 2'(3 - c);
    chk("first_setup_psel", PSEL, 1);
    chk("first_setup_penable", PENABLE, 0);
    chk("first_setup_paddr", PADDR, 4);
  endtask

  // From cycle 1; delay<0 means the slave never answers
  task automatic finish(input int delay, input logic [DW-1:0] dout, input logic [1:0] nerr);
    repeat (8) step();
    chk("wait_psel", PSEL, 0);
    chk("wait_penable", PENABLE, 0);
    chk("wait_pwrite", PWRITE, 0);
    chk("wait_paddr_hold", PADDR, 0);
    if (delay < 0) begin
      repeat (15) step();
      chk("res_valid_before_timeout", res_valid, 0);
      step();
      chk("res_valid_at_timeout", res_valid, 1);
    end else begin
      repeat (delay) step();
      operation_done = 1'b1; data_out = dout; num_of_errors = nerr;
      step();
      operation_done = 1'b0; data_out = $urandom; num_of_errors = 2'(~nerr);
      chk("res_valid_latency", res_valid, 1);
      chk("cmd_ready_in_resp", cmd_ready, 0);
    end
    step();
    chk("res_valid_one_cycle", res_valid, 0);
    chk("cmd_ready_after_resp", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_errors", res_errors, 0);
    chk("rst_res_timeout", res_timeout, 0);
    @(posedge clk); #1 rst = 1'b1;
    step();
    chk("rst_cmd_ready", cmd_ready, 1);

    // Encode
    issue(2'b00, 2'b00, 32'h0000_00A5, 32'h0, {1'b0, 2'b00, 32'h1234});
    finish(0, 32'h1234, 2'b00);
    // Full channel
    issue(2'b10, 2'b01, 32'hCAFE_F00D, 32'h0000_0004, {1'b0, 2'b01, 32'h55AA});
    finish(3, 32'h55AA, 2'b01);
    // Timeout
    issue(2'b01, 2'b10, 32'h1111_2222, 32'h8000_0001, {1'b1, 2'b00, 32'h0});
    finish(-1, 32'h0, 2'b00);
    // Done on the same cycle the timeout would fire
    issue(2'b01, 2'b11, 32'h0BAD_BEEF, 32'h0, {1'b0, 2'b10, 32'hBEEF});
    finish(15, 32'hBEEF, 2'b10);
    // ctrl=11 passes through
    issue(2'b11, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 2'b00, 32'h7777});
    finish(2, 32'h7777, 2'b00);

    // Backpressure with spurious done during SETUP
    issue(2'b00, 2'b01, 32'h0000_0A0A, 32'h0, {1'b0, 2'b11, 32'h0F0F});
    cmd_valid = 1'b1; cmd_ctrl = 2'b10; cmd_width = 2'b10;
    cmd_data = 32'h5A5A_0001; cmd_noise = 32'h0000_0100;
    operation_done = 1'b1; data_out = 32'hDEAD; num_of_errors = 2'b11;
    step();
    operation_done = 1'b0;
    chk("spurious_no_capture", res_data, 32'h7777);
    chk("busy_cmd_ready", cmd_ready, 0);
    repeat (7) step();
    chk("busy_cmd_ready_wait", cmd_ready, 0);
    operation_done = 1'b1; data_out = 32'h0F0F; num_of_errors = 2'b11;
    push_cmd(2'b10, 2'b10, 32'h5A5A_0001, 32'h0000_0100, {1'b0, 2'b01, 32'h4242});
    step();
    operation_done = 1'b0;
    chk("bp_res_valid", res_valid, 1);
    chk("bp_not_accepted_in_resp", cmd_ready, 0);
    step();
    chk("bp_ready_after_resp", cmd_ready, 1);
    step();
    cmd_valid = 1'b0; cmd_data = '0;
    chk("bp_second_setup_psel", PSEL, 1);
    chk("bp_second_setup_paddr", PADDR, 4);
    chk("bp_second_setup_pwdata", PWDATA, 32'h5A5A_0001);
    finish(1, 32'h4242, 2'b01);

    // Reset during NOISE ACCESS
    issue(2'b00, 2'b00, 32'h0000_3333, 32'h0000_0002, {1'b0, 2'b00, 32'h0});
    repeat (5) step();
    chk("noise_access_penable", PENABLE, 1);
    chk("noise_access_paddr", PADDR, 32'hC);
    #1 rst = 1'b0;
    #1;
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_data", res_data, 0);
    wr_q.delete();
    res_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    step();
    chk("midrst_cmd_ready", cmd_ready, 1);
    issue(2'b10, 2'b01, 32'h0000_00C3, 32'h0000_0010, {1'b0, 2'b01, 32'h00C3});
    finish(0, 32'h00C3, 2'b01);

    step();
    chk("wr_q_drained", wr_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
